// File: rtl/five_bit_full_subtractor_pkg.sv
// Shared width constant and a reference subtract for scoreboards.
package five_bit_full_subtractor_pkg;

  localparam int SUB_WIDTH = 5;

  // Returns {b_out, diff}: the top bit is the sign of the extended result.
  function automatic logic [SUB_WIDTH:0] sub_ref(
    input logic [SUB_WIDTH-1:0] a,
    input logic [SUB_WIDTH-1:0] b,
    input logic                 b_in
  );
    return {1'b0, a} - {1'b0, b} - {{SUB_WIDTH{1'b0}}, b_in};
  endfunction

endpackage

// File: rtl/five_bit_full_subtractor_cell.sv
// One-bit full subtractor cell, purely combinational.
module one_bit_full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/five_bit_full_subtractor.sv
// Registered ripple-borrow subtractor: {b_out, diff} = a - b - b_in, one cycle latency.
// Results load only on in_valid; otherwise they hold and out_valid drops.
module five_bit_full_subtractor
  import five_bit_full_subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             out_valid
);

  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] diff_d;
  logic [WIDTH-1:0] diff_q;
  logic             b_out_q;
  logic             out_valid_q;

  assign borrow[0] = b_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    one_bit_full_subtractor u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .bin (borrow[i]),
      .d   (diff_d[i]),
      .bout(borrow[i+1])
    );
  end

  // Gating the load on in_valid keeps idle-cycle X's out of the result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q      <= '0;
      b_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        diff_q  <= diff_d;
        b_out_q <= borrow[WIDTH];
      end
    end
  end

  assign diff      = diff_q;
  assign b_out     = b_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_five_bit_full_subtractor.sv
// Bench for five_bit_full_subtractor: directed edges plus random vectors vs an arithmetic model.
module tb_five_bit_full_subtractor;
  import five_bit_full_subtractor_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic [SUB_WIDTH-1:0] a;
  logic [SUB_WIDTH-1:0] b;
  logic                 b_in;
  logic [SUB_WIDTH-1:0] diff;
  logic                 b_out;
  logic                 out_valid;

  int checks = 0;
  int errors = 0;
  int exp_diff = 0;
  int exp_bout = 0;

  five_bit_full_subtractor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .b_in     (b_in),
    .diff     (diff),
    .b_out    (b_out),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Integer arithmetic model: wrap modulo 2^W, borrow when the true result is negative.
  task automatic model(input int av, input int bv, input int bi);
    int r;
    int m;
    m = 1 << SUB_WIDTH;
    r = av - bv - bi;
    exp_diff = (r + 2 * m) % m;
    exp_bout = (r < 0) ? 1 : 0;
  endtask

  task automatic check_outs(input string tag, input int vld);
    check({tag, ".diff"}, 32'(diff), 32'(exp_diff));
    check({tag, ".b_out"}, 32'(b_out), 32'(exp_bout));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(vld));
  endtask

  // Called at a falling edge: present an operation, let one rising edge pass, then check.
  task automatic op(input string tag, input int av, input int bv, input int bi);
    in_valid = 1'b1;
    a        = SUB_WIDTH'(av);
    b        = SUB_WIDTH'(bv);
    b_in     = bi[0];
    model(av, bv, bi);
    @(negedge clk);
    check_outs(tag, 1);
  endtask

  task automatic idle(input string tag);
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    b_in     = 1'bx;
    @(negedge clk);
    check_outs(tag, 0);
  endtask

  initial begin
    logic [SUB_WIDTH:0] ref_v;
    int av;
    int bv;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    b_in     = 1'b0;

    // Reset holds outputs clear across edges regardless of input activity.
    exp_diff = 0;
    exp_bout = 0;
    repeat (12) begin
      in_valid = 1'($urandom);
      a        = SUB_WIDTH'($urandom);
      b        = SUB_WIDTH'($urandom);
      b_in     = 1'($urandom);
      #3;
      check_outs("reset", 0);
    end

    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    op("d5m3", 5, 3, 0);
    op("d3m5", 3, 5, 0);
    op("bi0m0", 0, 0, 1);
    op("bi31m0", 31, 0, 1);
    op("bi31m31", 31, 31, 1);
    op("eq_nobi", 17, 17, 0);
    op("eq_bi", 9, 9, 1);

    for (int i = 0; i < 100; i++) begin
      av = int'($urandom_range(31, 0));
      bv = int'($urandom_range(31, 0));
      op("rand_bi0", av, bv, 0);
    end
    for (int i = 0; i < 256; i++) begin
      av = int'($urandom_range(31, 0));
      bv = int'($urandom_range(31, 0));
      op("rand_bi1", av, bv, 1);
    end

    // Package reference against the bench model.
    for (int i = 0; i < 16; i++) begin
      av = int'($urandom_range(31, 0));
      bv = int'($urandom_range(31, 0));
      model(av, bv, i & 1);
      ref_v = sub_ref(SUB_WIDTH'(av), SUB_WIDTH'(bv), 1'(i & 1));
      check("sub_ref", 32'(ref_v), 32'((exp_bout << SUB_WIDTH) | exp_diff));
    end

    // Hold with X inputs while idle.
    op("hold_load", 10, 4, 0);
    repeat (3) idle("hold");

    // Asynchronous reset between edges with a load in flight.
    op("pre_rst", 2, 7, 0);
    in_valid = 1'b1;
    a        = SUB_WIDTH'(20);
    b        = SUB_WIDTH'(1);
    b_in     = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_diff = 0;
    exp_bout = 0;
    check_outs("async_rst", 0);
    @(posedge clk);
    #1;
    check_outs("rst_edge", 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check_outs("post_rst", 0);
    op("post_rst_op", 1, 2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
